pwm_multi: RTL and testbench

Multi-channel successor to the single-channel PWM. It provides CHANNELS independent duty-cycle outputs that share one period counter, with a programmable period (TOP) and edge- or center-aligned counting. LFSR dither is clocked synchronously. Duty and period writes go through shadow registers, so they take effect glitch-free at the period boundary. It sits on the existing 8-bit register bus next to other bus peripherals.

---
 rtl/pwm_multi.sv | 248 ++++++++++++++++++++++++
 tb/tb_pwm_multi.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared period counter, programmable TOP, and
// edge- or center-aligned counting. Duty and TOP writes land in staging
// registers and are copied to the active set only at a period boundary,
// or when the block is enabled, so outputs never glitch mid-period.
// Optional LFSR dither adds a small per-period offset to every duty.

module pwm_multi #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned PWM_BITS = 10
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [7:0]          b_addr_i,
   input  logic [7:0]          b_data_i,
   output logic [7:0]          b_data_o,
   input  logic                b_write_i,
   output logic [CHANNELS-1:0] pwm_o,
   output logic                period_o
);

   localparam int unsigned W  = PWM_BITS;
   localparam int unsigned HW = PWM_BITS - 8;  // TOP/duty bits held in the hi byte

   localparam logic [7:0]   ADDR_CTL    = 8'h00;
   localparam logic [7:0]   ADDR_TOP_HI = 8'h01;
   localparam logic [7:0]   ADDR_TOP_LO = 8'h02;
   localparam logic [7:0]   ADDR_STATUS = 8'h03;
   localparam logic [W-1:0] TOP_RST     = '1;
   localparam logic [W-1:0] CNT_ONE     = W'(1);

   // Channel c occupies 0x10+4c (duty hi), 0x11+4c (duty lo), 0x12+4c (ctl).
   function automatic logic [7:0] chan_base(input int c);
      return 8'(16 + 4 * c);
   endfunction

   // Upper bits of a W-bit value as they appear in a hi byte, zero-padded.
   function automatic logic [7:0] hi_byte(input logic [W-1:0] v);
      logic [15:0] t;
      t = 16'(v);
      return t[15:8];
   endfunction

   // Control and staging state
   logic                en_q;
   logic                center_q;
   logic [1:0]          dsel_q;
   logic [W-1:0]        top_stage_q;
   logic                pending_q;
   logic [W-1:0]        duty_stage_q [CHANNELS];
   logic [CHANNELS-1:0] chan_en_q;
   logic [CHANNELS-1:0] chan_inv_q;

   // Active (shadowed) state and counter
   logic [W-1:0]        top_act_q;
   logic [W-1:0]        duty_act_q [CHANNELS];
   logic [W-1:0]        cnt_q;
   logic [W-1:0]        cnt_d;
   logic                dir_down_q;
   logic                dir_down_d;
   logic [7:0]          lfsr_q;
   logic [7:0]          lfsr_next;
   logic [CHANNELS-1:0] pwm_q;
   logic                period_q;

   // Decoded bus strobes and derived events
   logic                wr_ctl;
   logic                wr_top_hi;
   logic                wr_top_lo;
   logic [CHANNELS-1:0] wr_duty_hi;
   logic [CHANNELS-1:0] wr_duty_lo;
   logic [CHANNELS-1:0] wr_chan;
   logic                staging_write;
   logic                en_rise;
   logic                boundary;
   logic                load;
   logic [7:0]          dither;
   logic [CHANNELS-1:0] raw;

   // Address decode of write strobes
   always_comb begin
      wr_ctl     = b_write_i && (b_addr_i == ADDR_CTL);
      wr_top_hi  = b_write_i && (b_addr_i == ADDR_TOP_HI);
      wr_top_lo  = b_write_i && (b_addr_i == ADDR_TOP_LO);
      wr_duty_hi = '0;
      wr_duty_lo = '0;
      wr_chan    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         wr_duty_hi[c] = b_write_i && (b_addr_i == chan_base(c));
         wr_duty_lo[c] = b_write_i && (b_addr_i == chan_base(c) + 8'd1);
         wr_chan[c]    = b_write_i && (b_addr_i == chan_base(c) + 8'd2);
      end
      staging_write = wr_top_hi || wr_top_lo || (|wr_duty_hi) || (|wr_duty_lo);
   end

   // Period boundary, enable edge and shadow-load events
   always_comb begin
      en_rise = wr_ctl && b_data_i[7] && !en_q;
      if (!en_q) begin
         boundary = 1'b0;
      end else if (center_q) begin
         // TOP = 0 degenerates to a one-cycle period
         boundary = (top_act_q == '0) || ((cnt_q == '0) && dir_down_q);
      end else begin
         boundary = (cnt_q == top_act_q);
      end
      load = boundary || en_rise;
   end

   // Next counter value and direction
   always_comb begin
      cnt_d      = cnt_q;
      dir_down_d = dir_down_q;
      if (!en_q) begin
         // Also covers the enabling cycle: start from 0 counting up
         cnt_d      = '0;
         dir_down_d = 1'b0;
      end else if (!center_q) begin
         dir_down_d = 1'b0;
         cnt_d      = (cnt_q >= top_act_q) ? '0 : cnt_q + CNT_ONE;
      end else if (top_act_q == '0) begin
         cnt_d      = '0;
         dir_down_d = 1'b0;
      end else if (!dir_down_q) begin
         if (cnt_q >= top_act_q) begin
            dir_down_d = 1'b1;
            cnt_d      = cnt_q - CNT_ONE;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else if (cnt_q == '0) begin
         // Zero lasts one cycle: turn straight back up
         dir_down_d = 1'b0;
         cnt_d      = CNT_ONE;
      end else begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // Galois LFSR step and dither offset selection
   always_comb begin
      lfsr_next = {lfsr_q[6:4], lfsr_q[3] ^ lfsr_q[7], lfsr_q[2] ^ lfsr_q[7],
                   lfsr_q[1] ^ lfsr_q[7], lfsr_q[0], lfsr_q[7]};
      case (dsel_q)
         2'b01:   dither = {5'b0, lfsr_q[7:5]};
         2'b10:   dither = {3'b0, lfsr_q[7:3]};
         2'b11:   dither = {1'b0, lfsr_q[7:1]};
         default: dither = 8'h00;
      endcase
   end

   // Per-channel compare in W+1 bits so duty+dither never wraps
   always_comb begin
      raw = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         raw[c] = ({1'b0, cnt_q} < ({1'b0, duty_act_q[c]} + (W+1)'(dither)));
      end
   end

   // Register read-back, combinational from the address
   always_comb begin
      b_data_o = 8'h00;
      case (b_addr_i)
         ADDR_CTL:    b_data_o = {en_q, center_q, 4'b0000, dsel_q};
         ADDR_TOP_HI: b_data_o = hi_byte(top_stage_q);
         ADDR_TOP_LO: b_data_o = top_stage_q[7:0];
         ADDR_STATUS: b_data_o = {6'b0, dir_down_q, pending_q};
         default:     b_data_o = 8'h00;
      endcase
      for (int c = 0; c < CHANNELS; c++) begin
         if (b_addr_i == chan_base(c)) begin
            b_data_o = hi_byte(duty_stage_q[c]);
         end else if (b_addr_i == chan_base(c) + 8'd1) begin
            b_data_o = duty_stage_q[c][7:0];
         end else if (b_addr_i == chan_base(c) + 8'd2) begin
            b_data_o = {6'b0, chan_inv_q[c], chan_en_q[c]};
         end
      end
   end

   // Bus-writable control and TOP staging; a write wins over a load's clear of pending
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         en_q        <= 1'b0;
         center_q    <= 1'b0;
         dsel_q      <= 2'b00;
         top_stage_q <= TOP_RST;
         pending_q   <= 1'b0;
      end else begin
         if (wr_ctl) begin
            en_q     <= b_data_i[7];
            center_q <= b_data_i[6];
            dsel_q   <= b_data_i[1:0];
         end
         if (wr_top_hi) top_stage_q[W-1:8] <= b_data_i[HW-1:0];
         if (wr_top_lo) top_stage_q[7:0]   <= b_data_i;
         if (staging_write) begin
            pending_q <= 1'b1;
         end else if (load) begin
            pending_q <= 1'b0;
         end
      end
   end

   // Shared counter, active TOP, dither LFSR and period pulse
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         top_act_q  <= TOP_RST;
         cnt_q      <= '0;
         dir_down_q <= 1'b0;
         lfsr_q     <= 8'hFF;
         period_q   <= 1'b0;
      end else begin
         if (load) top_act_q <= top_stage_q;
         cnt_q      <= cnt_d;
         dir_down_q <= dir_down_d;
         if (boundary && (dsel_q != 2'b00)) lfsr_q <= lfsr_next;
         period_q   <= boundary;
      end
   end

   // Per-channel duty staging/active registers, channel control and outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            duty_stage_q[c] <= '0;
            duty_act_q[c]   <= '0;
         end
         chan_en_q  <= '0;
         chan_inv_q <= '0;
         pwm_q      <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (wr_duty_hi[c]) duty_stage_q[c][W-1:8] <= b_data_i[HW-1:0];
            if (wr_duty_lo[c]) duty_stage_q[c][7:0]   <= b_data_i;
            if (load) duty_act_q[c] <= duty_stage_q[c];
            if (wr_chan[c]) begin
               chan_en_q[c]  <= b_data_i[0];
               chan_inv_q[c] <= b_data_i[1];
            end
            pwm_q[c] <= en_q & chan_en_q[c] & (raw[c] ^ chan_inv_q[c]);
         end
      end
   end

   assign pwm_o    = pwm_q;
   assign period_o = period_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: expected (period length, high time) pairs for pwm_o[0]
// are queued by the stimulus and compared by a monitor that measures each
// window between period_o pulses. Register reads are checked directly.

module tb_pwm_multi;

   localparam int unsigned CH = 4;
   localparam int unsigned PB = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    b_addr;
   logic [7:0]    b_data;
   logic [7:0]    rdata;
   logic          b_write;
   logic [CH-1:0] pwm;
   logic          period;

   typedef struct {
      int len;
      int hi;
   } win_t;

   win_t exp_q[$];
   int   checks     = 0;
   int   failures   = 0;
   int   resync_req = 0;

   always #5 clk = ~clk;

   pwm_multi #(
      .CHANNELS(CH),
      .PWM_BITS(PB)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .b_addr_i (b_addr),
      .b_data_i (b_data),
      .b_data_o (rdata),
      .b_write_i(b_write),
      .pwm_o    (pwm),
      .period_o (period)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:4], l[3] ^ l[7], l[2] ^ l[7], l[1] ^ l[7], l[0], l[7]};
   endfunction

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      b_addr  = a;
      b_data  = d;
      b_write = 1'b1;
      @(posedge clk); #1;
      b_write = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [7:0] a, input int exp);
      @(posedge clk); #1;
      b_addr = a;
      #1;
      check_eq(tag, int'(rdata), exp);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_win(input int len, input int hi, input int n);
      win_t e;
      e.len = len;
      e.hi  = hi;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Window monitor: a window is every sample after one period_o pulse up to
   // and including the next; the first window after a resync is discarded.
   initial begin
      int   seen_req;
      bit   synced;
      int   len;
      int   hi;
      win_t e;
      seen_req = 0;
      synced   = 1'b0;
      len      = 0;
      hi       = 0;
      forever begin
         @(negedge clk);
         if (seen_req != resync_req) begin
            seen_req = resync_req;
            synced   = 1'b0;
         end
         if (synced) begin
            len++;
            if (pwm[0] === 1'b1) hi++;
         end
         if (period === 1'b1) begin
            if (synced && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_eq("win_len", len, e.len);
               check_eq("win_high", hi, e.hi);
            end
            synced = 1'b1;
            len    = 0;
            hi     = 0;
         end
      end
   end

   initial begin
      logic [7:0] l;
      int         n;

      rst     = 1'b1;
      b_addr  = 8'h00;
      b_data  = 8'h00;
      b_write = 1'b0;
      settle(3);
      check_eq("rst_pwm", int'(pwm), 0);
      check_eq("rst_period", int'(period), 0);
      rst = 1'b0;
      bus_read("rst_ctl", 8'h00, 8'h00);
      bus_read("rst_top_hi", 8'h01, 8'h03);
      bus_read("rst_top_lo", 8'h02, 8'hFF);
      bus_read("rst_status", 8'h03, 8'h00);
      bus_read("unmapped", 8'h13, 8'h00);

      // Edge mode, TOP=9, duty0=3
      bus_write(8'h01, 8'h00);
      bus_write(8'h02, 8'd9);
      bus_write(8'h10, 8'h00);
      bus_write(8'h11, 8'd3);
      bus_write(8'h12, 8'h01);
      bus_write(8'h13, 8'h55);
      bus_read("unmapped_wr", 8'h13, 8'h00);
      bus_read("pend_before_en", 8'h03, 8'h01);
      bus_read("top_lo_rd", 8'h02, 8'd9);
      resync_req++;
      bus_write(8'h00, 8'h80);
      bus_read("pend_after_en", 8'h03, 8'h00);
      push_win(10, 3, 3);
      wait_drain("drain_edge", 200);

      // Mid-period duty change takes effect at the next boundary
      push_win(10, 3, 1);
      bus_write(8'h11, 8'd7);
      bus_read("pend_mid", 8'h03, 8'h01);
      bus_read("duty_stage_rd", 8'h11, 8'd7);
      push_win(10, 7, 2);
      wait_drain("drain_duty7", 200);
      bus_read("pend_cleared", 8'h03, 8'h00);

      // Duty 0 with invert: constant high
      bus_write(8'h11, 8'd0);
      bus_write(8'h12, 8'h03);
      settle(25);
      push_win(10, 10, 2);
      wait_drain("drain_inv", 200);

      // Duty TOP+1: constant high
      bus_write(8'h11, 8'd10);
      bus_write(8'h12, 8'h01);
      settle(25);
      push_win(10, 10, 2);
      wait_drain("drain_full", 200);

      // Channel disabled: constant low
      bus_write(8'h12, 8'h00);
      settle(25);
      push_win(10, 0, 2);
      wait_drain("drain_chan_off", 200);

      // Center mode: period 2*TOP, zero and TOP each visited once per period
      bus_write(8'h11, 8'd3);
      bus_write(8'h12, 8'h01);
      bus_write(8'h00, 8'hC0);
      settle(45);
      push_win(18, 5, 2);
      wait_drain("drain_center", 300);

      // Center mode with TOP=0: every cycle is a boundary
      bus_write(8'h02, 8'd0);
      settle(30);
      push_win(1, 1, 3);
      wait_drain("drain_top0", 100);
      bus_write(8'h02, 8'd9);
      settle(45);
      push_win(18, 5, 1);
      wait_drain("drain_center2", 300);

      // Reset mid-period truncates the high phase immediately
      n = 0;
      while (pwm[0] !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("pre_rst_pwm", int'(pwm[0]), 1);
      rst = 1'b1;
      #1;
      check_eq("async_rst_pwm", int'(pwm), 0);
      check_eq("async_rst_period", int'(period), 0);
      settle(20);
      check_eq("held_rst_period", int'(period), 0);
      rst = 1'b0;
      resync_req++;
      bus_read("post_rst_ctl", 8'h00, 8'h00);
      bus_read("post_rst_top_hi", 8'h01, 8'h03);
      bus_read("post_rst_top_lo", 8'h02, 8'hFF);
      bus_read("post_rst_duty", 8'h11, 8'h00);

      // Dither select 11 from the reset LFSR value
      bus_write(8'h01, 8'h03);
      bus_write(8'h02, 8'hFF);
      bus_write(8'h11, 8'd100);
      bus_write(8'h12, 8'h01);
      resync_req++;
      bus_write(8'h00, 8'h83);
      l = 8'hFF;
      l = lfsr_step(l);
      for (int k = 0; k < 3; k++) begin
         push_win(1024, 100 + int'(l >> 1), 1);
         l = lfsr_step(l);
      end
      wait_drain("drain_dither", 4500);

      // Select 00: no dither and the LFSR must not advance
      bus_write(8'h00, 8'h80);
      resync_req++;
      push_win(1024, 100, 2);
      wait_drain("drain_nodither", 3500);
      bus_write(8'h00, 8'h83);
      push_win(1024, 100 + int'(l >> 1), 1);
      l = lfsr_step(l);
      push_win(1024, 100 + int'(l >> 1), 1);
      wait_drain("drain_redither", 2500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
